// File: rtl/bitty_fetch_unit.sv
// Instruction fetch/issue sequencer for the bitty core: fetch, load, issue, await done.
// Optional EXEC watchdog enabled by defining FETCH_TIMEOUT_EN.
module bitty_fetch_unit #(
   parameter int unsigned ADDR_W      = 8,
   parameter logic [15:0] HALT_WORD   = 16'hFFFF,
   parameter int unsigned TIMEOUT_CYC = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_data,
   output logic              run,
   output logic [15:0]       instruction,
   input  logic              done,
   output logic              busy,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       instr_count,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      ISSUE,
      EXEC,
      HALTED
   } state_t;

   localparam logic [ADDR_W-1:0] PC_LAST = '1;

   state_t state, state_nxt;
   logic   prog_clr;
   logic   pc_inc;
   logic   cnt_inc;
   logic   instr_ld;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] timer;
   logic          timer_exp;
   logic          to_set;

   assign timer_exp = (timer == TW'(TIMEOUT_CYC - 1));
`endif

   always_comb begin
      state_nxt = state;
      prog_clr  = 1'b0;
      pc_inc    = 1'b0;
      cnt_inc   = 1'b0;
      instr_ld  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      to_set    = 1'b0;
`endif
      case (state)
         IDLE, HALTED: begin
            if (start) begin
               prog_clr  = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: state_nxt = LOAD;
         LOAD: begin
            // a halt word is never latched, so the core keeps seeing the last issued word
            if (mem_data == HALT_WORD) begin
               state_nxt = HALTED;
            end else begin
               instr_ld  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = EXEC;
         EXEC: begin
            if (done) begin
               cnt_inc = 1'b1;
               if (pc == PC_LAST) begin
                  state_nxt = HALTED;
               end else begin
                  pc_inc    = 1'b1;
                  state_nxt = FETCH;
               end
            end
`ifdef FETCH_TIMEOUT_EN
            else if (timer_exp) begin
               to_set    = 1'b1;
               state_nxt = HALTED;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= '0;
         instr_count <= '0;
         instruction <= '0;
      end else begin
         state <= state_nxt;
         if (prog_clr) begin
            pc          <= '0;
            instr_count <= '0;
         end else begin
            if (pc_inc) begin
               pc <= pc + 1'b1;
            end
            if (cnt_inc && (instr_count != '1)) begin
               instr_count <= instr_count + 16'd1;
            end
         end
         if (instr_ld) begin
            instruction <= mem_data;
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // timer is zero whenever EXEC is entered because it is held clear outside EXEC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer       <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == EXEC) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end
         if (prog_clr) begin
            timeout_err <= 1'b0;
         end else if (to_set) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   assign mem_rd_en = (state == FETCH);
   assign mem_addr  = pc;
   assign run       = (state == ISSUE);
   assign busy      = (state != IDLE) && (state != HALTED);
   assign halted    = (state == HALTED);

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: schedule-based reference model of the
// fetch/issue timeline, with a synchronous memory and a latency-programmable core stub.
module tb_bitty_fetch_unit;

   localparam int unsigned AW = 4;
   localparam int          NW = 16;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_data;
   logic          run;
   logic [15:0]   instruction;
   logic          done;
   logic          busy;
   logic          halted;
   logic [AW-1:0] pc;
   logic [15:0]   instr_count;
   logic          timeout_err;

   always #5 clk = ~clk;

   logic [15:0] mem [NW];
   always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

   bitty_fetch_unit #(
      .ADDR_W      (AW),
      .HALT_WORD   (16'hFFFF),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .run         (run),
      .instruction (instruction),
      .done        (done),
      .busy        (busy),
      .halted      (halted),
      .pc          (pc),
      .instr_count (instr_count),
      .timeout_err (timeout_err)
   );

   int checks = 0;
   int errors = 0;
   int lat [NW];
   int obs_run [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_run"}, 32'(run), 32'd0);
      chk({tag, "_rd"}, 32'(mem_rd_en), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
      chk({tag, "_pc"}, 32'(pc), 32'd0);
      chk({tag, "_cnt"}, 32'(instr_count), 32'd0);
      chk({tag, "_instr"}, 32'(instruction), 32'd0);
      chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
   endtask

   // Timeline model: period 0 carries start; issue k runs at runp[k], done at runp[k]+lat[k],
   // and the next fetch/load/issue follow in the three periods after each done.
   task automatic run_program(input int abort_at, input bit noisy);
      int n, h_fetch, hp, ndone, fin_pc;
      int runp [NW];
      int donep [NW];
      bit halt_word, exp_run, exp_rd, in_exec, done_now;
      n = 0;
      while (n < NW && mem[n] != 16'hFFFF) n++;
      halt_word = (n < NW);
      for (int k = 0; k < n; k++) begin
         runp[k]  = (k == 0) ? 3 : donep[k-1] + 3;
         donep[k] = runp[k] + lat[k];
      end
      h_fetch = halt_word ? ((n == 0) ? 1 : donep[n-1] + 1) : -1;
      hp      = halt_word ? h_fetch + 2 : donep[n-1] + 1;
      fin_pc  = halt_word ? n : NW - 1;
      obs_run.delete();

      @(negedge clk);
      start = 1'b1;
      done  = 1'b0;
      for (int p = 1; p <= hp + 3; p++) begin
         @(negedge clk);
         start = 1'b0;
         done  = 1'b0;
         if (p == abort_at) begin
            reset = 1'b0;
            #1;
            chk_all_zero("abort");
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         exp_run  = 1'b0;
         exp_rd   = (p == h_fetch);
         in_exec  = 1'b0;
         done_now = 1'b0;
         ndone    = 0;
         for (int k = 0; k < n; k++) begin
            if (runp[k] == p) exp_run = 1'b1;
            if (runp[k] - 2 == p) exp_rd = 1'b1;
            if (donep[k] < p) ndone++;
            if (p > runp[k] && p <= donep[k]) in_exec = 1'b1;
            if (donep[k] == p) done_now = 1'b1;
            if (p >= runp[k] && p <= donep[k]) chk("instr_hold", 32'(instruction), 32'(mem[k]));
         end
         if (run) obs_run.push_back(p);
         chk("run", 32'(run), 32'(exp_run));
         chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
         chk("busy", 32'(busy), 32'(p < hp));
         chk("halted", 32'(halted), 32'(p >= hp));
         chk("pc", 32'(pc), 32'((ndone > NW - 1) ? NW - 1 : ndone));
         chk("mem_addr", 32'(mem_addr), 32'((ndone > NW - 1) ? NW - 1 : ndone));
         chk("instr_count", 32'(instr_count), 32'(ndone));
         chk("timeout_err", 32'(timeout_err), 32'd0);
         if (done_now) done = 1'b1;
         else if (noisy && !in_exec && $urandom_range(0, 2) == 0) done = 1'b1;
         if (noisy && p < hp && $urandom_range(0, 2) == 0) start = 1'b1;
      end
      chk("final_halted", 32'(halted), 32'd1);
      chk("final_pc", 32'(pc), 32'(fin_pc));
      chk("final_count", 32'(instr_count), 32'(n));
      chk("run_pulses", 32'(obs_run.size()), 32'(n));
      if (n > 0) chk("instr_after_halt", 32'(instruction), 32'(mem[n-1]));
   endtask

   task automatic idle_noise(input int cycles, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         done = 1'b1;
         start = 1'b0;
         chk("noise_busy", 32'(busy), 32'd0);
         chk("noise_pc", 32'(pc), exp_pc);
         chk("noise_cnt", 32'(instr_count), exp_cnt);
      end
      @(negedge clk);
      done = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      done  = 1'b0;
      for (int i = 0; i < NW; i++) begin
         mem[i] = 16'h0;
         lat[i] = 1;
      end
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;

      idle_noise(3, 32'd0, 32'd0);

      // halt after two instructions, 4-cycle core
      mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hFFFF;
      for (int i = 0; i < NW; i++) lat[i] = 4;
      run_program(-1, 1'b0);
      idle_noise(2, 32'd2, 32'd2);

      // issue latency: run pulses land on periods 3 and 8
      for (int i = 0; i < NW; i++) lat[i] = 2;
      run_program(-1, 1'b0);
      chk("first_run_period", 32'(obs_run[0]), 32'd3);
      chk("second_run_period", 32'(obs_run[1]), 32'd8);

      // no halt word: runs to the end of the program space
      for (int i = 0; i < NW; i++) begin
         mem[i] = 16'h0001;
         lat[i] = 1;
      end
      run_program(-1, 1'b0);

      // reset while the third instruction is executing (lat 3: runs at 3, 9, 15)
      for (int i = 0; i < NW; i++) lat[i] = 3;
      run_program(16, 1'b0);
      idle_noise(3, 32'd0, 32'd0);
      mem[4] = 16'hFFFF;
      run_program(-1, 1'b1);

`ifdef FETCH_TIMEOUT_EN
      mem[0] = 16'hABCD; mem[1] = 16'hFFFF;
      @(negedge clk);
      start = 1'b1;
      for (int p = 1; p <= 15; p++) begin
         @(negedge clk);
         start = 1'b0;
         chk("to_run", 32'(run), 32'(p == 3));
         chk("to_busy", 32'(busy), 32'(p < 12));
         chk("to_halted", 32'(halted), 32'(p >= 12));
         chk("to_err", 32'(timeout_err), 32'(p >= 12));
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      chk("to_late_done_cnt", 32'(instr_count), 32'd0);
      chk("to_late_done_pc", 32'(pc), 32'd0);
      chk("to_err_sticky", 32'(timeout_err), 32'd1);
      lat[0] = 2;
      run_program(-1, 1'b0);
`else
      // without the watchdog a slow core is simply waited for
      mem[0] = 16'hABCD; mem[1] = 16'hFFFF;
      lat[0] = 40;
      run_program(-1, 1'b0);
`endif

      for (int t = 0; t < 8; t++) begin
         int hpos;
         hpos = $urandom_range(0, NW);
         for (int i = 0; i < NW; i++) begin
            mem[i] = 16'($urandom_range(0, 16'hFFFE));
            lat[i] = $urandom_range(1, 6);
         end
         if (hpos < NW) mem[hpos] = 16'hFFFF;
         run_program(-1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog simulation_time_limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
